// File: rtl/seg7_pkg.sv
// Glyph table and FSM encodings shared by the 7-segment encoder and the scan decoder.
package seg7_pkg;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  typedef enum logic [1:0] {
    S_WAIT  = ST_WAIT,
    S_COUNT = ST_COUNT,
    S_HELD  = ST_HELD
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the glyph table: segment pattern to hex nibble plus legality flag.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = '0;
    legal  = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, qualifies each digit by dwell stability and
// reassembles the displayed multi-digit hex value.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            hex_i,
  input  logic [DIGITS-1:0]     an_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     digit_err_o,
  output logic                  valid_o,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  scan_state_e         state;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_err;
  logic [DIGITS-1:0]   seen;

  logic [3:0]          dec_nib;
  logic                dec_legal;
  logic [IW-1:0]       idx;
  logic                qual;
  logic                same;
  logic [CW-1:0]       cnt_inc;
  logic                capture;
  logic [4*DIGITS-1:0] shadow_val_nx;
  logic [DIGITS-1:0]   shadow_err_nx;
  logic [DIGITS-1:0]   seen_nx;

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .nibble  (dec_nib),
    .legal   (dec_legal)
  );

  // Stability is judged by the incoming sample matching the registered pair, so a
  // pair registered at edge 0 reaches STABLE_CYCLES at edge STABLE_CYCLES.
  assign same    = (an_i == an_q) && (hex_i == seg_q);
  assign qual    = ($countones(~an_q) == 1);
  assign cnt_inc = cnt + CW'(1);
  assign capture = same && qual && (state != S_HELD) && (cnt_inc == CNT_MAX);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) idx = IW'(i);
    end
  end

  always_comb begin
    shadow_val_nx               = shadow_val;
    shadow_err_nx               = shadow_err;
    shadow_val_nx[idx*4 +: 4]   = dec_nib;
    shadow_err_nx[idx]          = ~dec_legal;
    seen_nx                     = seen | (DIGITS'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      state       <= S_WAIT;
      cnt         <= '0;
      shadow_val  <= '0;
      shadow_err  <= '0;
      seen        <= '0;
      value_o     <= '0;
      digit_err_o <= '0;
      err_o       <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      an_q    <= an_i;
      seg_q   <= hex_i;
      valid_o <= 1'b0;
      if (!same || !qual) begin
        state <= S_WAIT;
        cnt   <= '0;
      end else if (state == S_HELD) begin
        cnt <= CNT_MAX;
      end else if (capture) begin
        state      <= S_HELD;
        cnt        <= cnt_inc;
        shadow_val <= shadow_val_nx;
        shadow_err <= shadow_err_nx;
        if (&seen_nx) begin
          value_o     <= shadow_val_nx;
          digit_err_o <= shadow_err_nx;
          err_o       <= |shadow_err_nx;
          valid_o     <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_nx;
        end
      end else begin
        state <= S_COUNT;
        cnt   <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: scans push expected frames, a monitor pops on valid_o.
module tb_seg7_scan_decoder;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  hex_i;
  logic [7:0]  an_i;
  logic [31:0] value_o;
  logic [7:0]  digit_err_o;
  logic        valid_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  derr;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  logic prev_valid = 1'b0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .hex_i       (hex_i),
    .an_i        (an_i),
    .value_o     (value_o),
    .digit_err_o (digit_err_o),
    .valid_o     (valid_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one anode/pattern pair for dwell clock edges; called at a negedge.
  task automatic drive(input logic [7:0] an, input logic [6:0] g, input int dwell);
    an_i  = an;
    hex_i = g;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic show(input int d, input int nib, input int dwell);
    logic [7:0] one;
    one = 8'b1 << d;
    drive(~one, glyph_tab[nib], dwell);
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      frame_t e;
      valid_cnt++;
      chk("valid_not_back_to_back", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got value %h with no frame expected", value_o);
      end else begin
        e = exp_q.pop_front();
        chk("value", value_o, e.val);
        chk("digit_err", {24'b0, digit_err_o}, {24'b0, e.derr});
        chk("err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
    prev_valid = valid_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    rst   = 1'b1;
    an_i  = '1;
    hex_i = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_value", value_o, 32'h0);
    chk("rst_derr", {24'b0, digit_err_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Clean scan of glyphs 1..8
    exp_q.push_back('{32'h87654321, 8'h00, 1'b0});
    for (int d = 0; d < 8; d++) show(d, d + 1, 10);

    // Illegal pattern on digit 3
    exp_q.push_back('{32'h87650321, 8'h08, 1'b1});
    for (int d = 0; d < 8; d++) begin
      if (d == 3) drive(~8'h08, 7'b0001001, 10);
      else show(d, d + 1, 10);
    end

    // Digit 2 one clock too short: frame must stay open until it is rescanned
    drive('1, 7'h7F, 3);
    vc = valid_cnt;
    for (int d = 0; d < 8; d++) show(d, d + 1, (d == 2) ? STABLE : 10);
    drive('1, 7'h7F, 3);
    chk("short_dwell_no_frame", vc, valid_cnt);
    exp_q.push_back('{32'h87654321, 8'h00, 1'b0});
    show(2, 3, 10);

    // Blanking and two-low anode patterns between digits are ignored
    exp_q.push_back('{32'h87654321, 8'h00, 1'b0});
    for (int d = 0; d < 8; d++) begin
      show(d, d + 1, 10);
      drive('1, glyph_tab[0], 10);
      drive(8'b1101_1110, glyph_tab[0], 10);
    end

    // Digit 0 recaptured before frame end
    exp_q.push_back('{32'h8765432F, 8'h00, 1'b0});
    show(0, 10, 10);
    show(0, 15, 10);
    for (int d = 1; d < 8; d++) show(d, d + 1, 10);

    // Reset mid-frame discards the partial frame
    for (int d = 0; d < 5; d++) show(d, 1, 10);
    rst  = 1'b1;
    an_i = '1;
    @(negedge clk);
    chk("midrst_value", value_o, 32'h0);
    chk("midrst_derr", {24'b0, digit_err_o}, 32'h0);
    chk("midrst_err", {31'b0, err_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_value", value_o, 32'h0);
    vc = valid_cnt;
    for (int d = 5; d < 8; d++) show(d, 14, 10);
    drive('1, 7'h7F, 3);
    chk("postrst_partial_no_frame", vc, valid_cnt);
    exp_q.push_back('{32'hEEEEEEEE, 8'h00, 1'b0});
    for (int d = 0; d < 5; d++) show(d, 14, 10);
    drive('1, 7'h7F, 10);

    chk("hold_value", value_o, 32'hEEEEEEEE);
    chk("queue_empty", exp_q.size(), 0);
    chk("valid_count", valid_cnt, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
